// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with sequential, jump, branch and
// call/return sequencing through a small return-address stack.
module pc_sequencer #(
    parameter int                WIDTH      = 8,
    parameter int                STEP       = 1,
    parameter int                DEPTH      = 4,
    parameter logic [WIDTH-1:0]  RESET_ADDR = '0,
    localparam int               SP_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       op,
    input  logic             cond,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] pc,
    output logic [SP_W-1:0]  sp,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam int               IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [SP_W-1:0]  FULL_N = SP_W'(DEPTH);

    localparam logic [2:0] OP_JUMP   = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;

    logic [WIDTH-1:0] stack [DEPTH];

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] pc_next;
    logic [SP_W-1:0]  sp_next;
    logic [SP_W-1:0]  sp_dec;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic             ovf_next;
    logic             unf_next;
    logic             push;

    assign stack_full  = (sp == FULL_N);
    assign stack_empty = (sp == '0);
    assign seq_pc      = pc + STEP_W;
    assign sp_dec      = sp - SP_W'(1);
    assign push_idx    = IDX_W'(sp);
    assign top_idx     = IDX_W'(sp_dec);

    always_comb begin
        pc_next  = seq_pc;
        sp_next  = sp;
        ovf_next = ovf_err;
        unf_next = unf_err;
        push     = 1'b0;
        case (op)
            OP_JUMP:   pc_next = target;
            OP_BRANCH: pc_next = cond ? pc + offset : seq_pc;
            OP_CALL: begin
                if (stack_full) begin
                    pc_next  = pc;
                    ovf_next = 1'b1;
                end else begin
                    pc_next = target;
                    sp_next = sp + SP_W'(1);
                    push    = 1'b1;
                end
            end
            OP_RET: begin
                if (stack_empty) begin
                    pc_next  = pc;
                    unf_next = 1'b1;
                end else begin
                    pc_next = stack[top_idx];
                    sp_next = sp_dec;
                end
            end
            default:   pc_next = seq_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc      <= RESET_ADDR;
            sp      <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else if (!stall) begin
            pc      <= pc_next;
            sp      <= sp_next;
            ovf_err <= ovf_next;
            unf_err <= unf_next;
        end
    end

    // Stack contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (reset && !stall && push) begin
            stack[push_idx] <= seq_pc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer against a queue-based
// reference model of the call/return program counter.
module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic       stall;
    logic [2:0] op;
    logic       cond;
    logic [7:0] target;
    logic [7:0] offset;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       stack_full;
    logic       stack_empty;
    logic       ovf_err;
    logic       unf_err;

    pc_sequencer #(
        .WIDTH(8),
        .STEP(1),
        .DEPTH(4),
        .RESET_ADDR(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .op(op),
        .cond(cond),
        .target(target),
        .offset(offset),
        .pc(pc),
        .sp(sp),
        .stack_full(stack_full),
        .stack_empty(stack_empty),
        .ovf_err(ovf_err),
        .unf_err(unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_pc;
    int m_stack[$];
    bit m_ovf;
    bit m_unf;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int o;
        if (!reset) begin
            m_pc = 0;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (!stall) begin
            o = int'(op);
            if (o == 1) begin
                m_pc = int'(target);
            end else if (o == 2) begin
                if (cond) m_pc = (m_pc + int'(offset)) % 256;
                else      m_pc = (m_pc + 1) % 256;
            end else if (o == 3) begin
                if (m_stack.size() == 4) m_ovf = 1;
                else begin
                    m_stack.push_back((m_pc + 1) % 256);
                    m_pc = int'(target);
                end
            end else if (o == 4) begin
                if (m_stack.size() == 0) m_unf = 1;
                else m_pc = m_stack.pop_back();
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [2:0] o,
                        input logic c, input logic [7:0] t,
                        input logic [7:0] f);
        reset  = r;
        stall  = s;
        op     = o;
        cond   = c;
        target = t;
        offset = f;
        @(posedge clk);
        model_update();
        #1;
        check("pc", 32'(pc), 32'(m_pc));
        check("sp", 32'(sp), 32'(m_stack.size()));
        check("full", 32'(stack_full), 32'(m_stack.size() == 4));
        check("empty", 32'(stack_empty), 32'(m_stack.size() == 0));
        check("ovf", 32'(ovf_err), 32'(m_ovf));
        check("unf", 32'(unf_err), 32'(m_unf));
    endtask

    task automatic run(input logic [2:0] o, input logic c,
                       input logic [7:0] t, input logic [7:0] f);
        step(1'b1, 1'b0, o, c, t, f);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; op = '0;
        cond = 1'b0; target = '0; offset = '0;
        m_pc = 0; m_ovf = 0; m_unf = 0;

        step(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 3'd1, 1'b0, 8'h55, 8'h00);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_empty", 32'(stack_empty), 32'h1);

        run(3'd0, 0, 8'h00, 8'h00);
        check("inc1", 32'(pc), 32'h1);
        run(3'd0, 0, 8'h00, 8'h00);
        run(3'd7, 0, 8'h00, 8'h00);
        check("inc3", 32'(pc), 32'h3);
        run(3'd1, 0, 8'hFF, 8'h00);
        run(3'd0, 0, 8'h00, 8'h00);
        check("wrap", 32'(pc), 32'h0);

        run(3'd1, 0, 8'h10, 8'h00);
        step(1'b1, 1'b1, 3'd1, 1'b0, 8'h40, 8'h00);
        check("stall_pc", 32'(pc), 32'h10);
        run(3'd3, 0, 8'h50, 8'h00);
        step(1'b0, 1'b1, 3'd1, 1'b0, 8'h40, 8'h00);
        check("rst_stall_pc", 32'(pc), 32'h0);
        check("rst_stall_sp", 32'(sp), 32'h0);

        run(3'd1, 0, 8'h10, 8'h00);
        run(3'd2, 1, 8'h00, 8'hFC);
        check("br_back", 32'(pc), 32'h0C);
        run(3'd2, 0, 8'h00, 8'hFC);
        check("br_nt", 32'(pc), 32'h0D);
        run(3'd1, 0, 8'h02, 8'h00);
        run(3'd2, 1, 8'h00, 8'hFC);
        check("br_wrap", 32'(pc), 32'hFE);

        run(3'd1, 0, 8'h20, 8'h00);
        run(3'd3, 0, 8'h80, 8'h00);
        run(3'd3, 0, 8'h90, 8'h00);
        check("call_sp", 32'(sp), 32'h2);
        run(3'd4, 0, 8'h00, 8'h00);
        check("ret1", 32'(pc), 32'h81);
        run(3'd4, 0, 8'h00, 8'h00);
        check("ret2", 32'(pc), 32'h21);
        check("ret_empty", 32'(stack_empty), 32'h1);

        for (int i = 0; i < 4; i++) run(3'd3, 0, 8'(8'h40 + i), 8'h00);
        check("full4", 32'(stack_full), 32'h1);
        run(3'd3, 0, 8'hAA, 8'h00);
        check("ovf_pc", 32'(pc), 32'h43);
        check("ovf_sp", 32'(sp), 32'h4);
        check("ovf_flag", 32'(ovf_err), 32'h1);
        run(3'd0, 0, 8'h00, 8'h00);
        check("ovf_inc", 32'(pc), 32'h44);
        check("ovf_sticky", 32'(ovf_err), 32'h1);

        step(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
        check("ovf_clr", 32'(ovf_err), 32'h0);
        run(3'd4, 0, 8'h00, 8'h00);
        check("unf_pc", 32'(pc), 32'h0);
        check("unf_flag", 32'(unf_err), 32'h1);
        run(3'd1, 0, 8'h33, 8'h00);
        check("unf_jump", 32'(pc), 32'h33);
        check("unf_sticky", 32'(unf_err), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic s;
            logic [2:0] o;
            r = ($urandom_range(0, 99) != 0);
            s = ($urandom_range(0, 7) == 0);
            o = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                           : 3'($urandom_range(3, 4));
            if ($urandom_range(0, 2) == 0) o = 3'($urandom_range(0, 2));
            step(r, s, o, 1'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program counter for the processor fetch stage. Generates the instruction address each cycle and supports sequential increment, absolute jump, conditional relative branch, and call/return through an internal return-address stack. It replaces the fixed 8-bit free-running counter and feeds the instruction memory address port directly.

## Interface
- WIDTH, 8, address width in bits (≥4)
- STEP, 1, sequential increment added to pc
- DEPTH, 4, return-address stack entries (≥1)
- RESET_ADDR, 0, pc value after reset
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low; clock clk
- stall  in  1  hold pc and stack this cycle
- op  in  3  operation: 000 INC, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET; 101–111 behave as INC
- cond  in  1  branch condition, used only by BRANCH
- target  in  WIDTH  absolute address for JUMP/CALL
- offset  in  WIDTH  two's-complement displacement for BRANCH
- pc  out  WIDTH  current instruction address (registered)
- sp  out  clog2(DEPTH+1)  number of valid stack entries
- stack_full  out  1  sp == DEPTH
- stack_empty  out  1  sp == 0
- ovf_err  out  1  sticky: CALL attempted while full
- unf_err  out  1  sticky: RET attempted while empty

## Operation
- Reset (reset==0 at edge): pc=RESET_ADDR, sp=0, ovf_err=0, unf_err=0, stack contents don't-care. Reset overrides stall and op.
- stall==1: pc, sp, stack and error flags unchanged; op ignored.
- INC: pc ← pc + STEP.
- JUMP: pc ← target.
- BRANCH: cond==1 → pc ← pc + offset (offset sign-extended; WIDTH-bit add). cond==0 → pc ← pc + STEP.
- CALL, not full: stack[sp] ← pc + STEP, sp ← sp+1, pc ← target.
- CALL, full: no push, pc unchanged, ovf_err ← 1.
- RET, not empty: pc ← stack[sp-1], sp ← sp-1.
- RET, empty: pc unchanged, unf_err ← 1.
- Arithmetic is modulo 2^WIDTH: pc wraps from 2^WIDTH−STEP upward to low addresses with no flag; backward branches wrap below 0 likewise.
- Return address pushed on CALL is also computed modulo 2^WIDTH.
- Error flags clear only on reset; a faulting CALL/RET does not otherwise block later operations.
- stack_full / stack_empty are combinational from sp.

## Timing
- Single-cycle: op/cond/target/offset sampled at rising edge N; new pc visible after edge N. No pipeline bubble.
- pc is valid one clock after reset deasserts: the first edge with reset==1 performs the op presented in that cycle, starting from RESET_ADDR.
- The RET read uses the current stack top in the same cycle. Back-to-back CALL→RET returns to the address pushed one cycle earlier.
- Consecutive CALLs up to DEPTH all succeed. The (DEPTH+1)th CALL faults.
- sp, stack_full, stack_empty and the error flags update on the same edge as pc.

## Test plan
- Reset/INC: WIDTH=8, STEP=1; hold reset=0 for 2 cycles, then INC for 3 cycles → pc 0,1,2,3; pc=255 followed by INC → 0.
- Stall/reset priority: stall=1 with op=JUMP target=0x40 → pc unchanged. Assert reset=0 during stall → pc=RESET_ADDR, sp=0.
- Branch: pc=0x10; BRANCH cond=1 offset=0xFC → pc=0x0C. BRANCH cond=0 → pc=0x0D. pc=0x02 with offset=0xFC → pc=0xFE.
- Call/return nesting: DEPTH=4; from pc=0x20, CALL 0x80, then CALL 0x90 → sp=2. RET → pc=0x81. RET → pc=0x21, stack_empty=1.
- Overflow: perform 4 CALLs → stack_full=1. A 5th CALL target=0xAA → pc unchanged, sp=4, ovf_err=1. A following INC works and ovf_err stays 1 until reset.
- Underflow: with sp=0, RET → pc unchanged, unf_err=1. Then JUMP 0x33 → pc=0x33, and unf_err stays 1.
